cache_arbiter: RTL
==================

Name: cache_arbiter

Overview:
- Shares the single physical-memory line port between the instruction cache (fetch misses from the IF stage) and the data cache (MEM-stage misses and writebacks).
- One transaction is in flight at a time.
- Ownership is decided by a registered round-robin grant with a 3-state FSM.
- Sits between the two caches and the cacheline adaptor.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- LINE_WIDTH, 256, cache line width in bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; all state is cleared while low.
- i_read  input  1  icache line read request.
- i_addr  input  ADDR_WIDTH  icache line address, line-aligned.
- i_rdata  output  LINE_WIDTH  line returned to icache.
- i_resp  output  1  icache transaction complete; 1-cycle pulse.
- d_read  input  1  dcache line read request.
- d_write  input  1  dcache line write (writeback) request.
- d_addr  input  ADDR_WIDTH  dcache line address.
- d_wdata  input  LINE_WIDTH  dcache writeback data.
- d_rdata  output  LINE_WIDTH  line returned to dcache.
- d_resp  output  1  dcache transaction complete; 1-cycle pulse.
- mem_read  output  1  read request to memory.
- mem_write  output  1  write request to memory.
- mem_addr  output  ADDR_WIDTH  memory address.
- mem_wdata  output  LINE_WIDTH  memory write data.
- mem_rdata  input  LINE_WIDTH  memory read data.
- mem_resp  input  1  memory transaction complete.

Behaviour:
- States:
  - IDLE: no owner.
  - SERVE_I: icache owns the port.
  - SERVE_D: dcache owns the port.
- Registers: state, last_grant (0 = I, 1 = D).
- Reset (reset == 0, asynchronous):
  - state = IDLE, last_grant = D, so the icache wins the first tie.
  - All outputs = 0.
- IDLE transitions:
  - Only I pending (i_read): go to SERVE_I.
  - Only D pending (d_read | d_write): go to SERVE_D.
  - Both pending: grant the requester not equal to last_grant.
  - None pending: stay in IDLE.
  - last_grant updates on the grant edge.
- IDLE outputs: mem_read = mem_write = 0, mem_addr = 0, mem_wdata = 0, i_resp = d_resp = 0.
- SERVE_I, combinational outputs:
  - mem_read = i_read, mem_write = 0.
  - mem_addr = i_addr, mem_wdata = 0.
  - i_resp = mem_resp.
  - i_rdata = mem_rdata.
- SERVE_D, combinational outputs:
  - mem_read = d_read, mem_write = d_write.
  - mem_addr = d_addr, mem_wdata = d_wdata.
  - d_resp = mem_resp.
  - d_rdata = mem_rdata.
- Completion: mem_resp in SERVE_x causes the next state to be IDLE. A new grant needs at least one IDLE cycle, so back-to-back transactions are separated by one turnaround cycle.
- Latency: request seen in IDLE at cycle N gives mem_read/mem_write asserted in cycle N+1. The response arrives in the same cycle as mem_resp.
- Non-owner isolation: the non-owner's resp is 0 and its rdata is 0. Its request is held pending, never dropped; the arbiter has no request queue.
- Protocol assumption: requesters hold request, address and data stable until their resp. The arbiter does not register them.
- Requester deasserts before mem_resp (protocol violation):
  - The arbiter stays in SERVE_x until mem_resp.
  - Mem strobes follow the requester's deasserted level.
- Simultaneous d_read & d_write: illegal. The arbiter forwards both unchanged.
- mem_resp in IDLE: ignored, no resp pulse.
- Reset asserted mid-transaction: immediate return to IDLE with outputs 0. The memory side is reset by the same signal.
- Fairness: neither cache waits more than one foreign transaction plus one turnaround cycle.

Decomposition:
- Package arbiter_types:
  - enum arb_state_t {IDLE, SERVE_I, SERVE_D}.
  - enum grant_t {GRANT_I, GRANT_D}.
- Single module. The round-robin pick is a few lines of always_comb, so no sub-module is needed.

Test Plan:
- Reset low then high; no requests for 5 cycles -> all mem_* and resp outputs stay 0, state IDLE.
- i_read, i_addr=0x0000_0040; mem_resp asserted 3 cycles after mem_read -> mem_read rises 1 cycle after i_read, mem_addr=0x40, i_resp pulses 1 cycle, i_rdata = mem_rdata, d_resp stays 0.
- i_read and d_write (d_addr=0x8000_0100, d_wdata=all 0xA5) asserted together out of reset -> icache served first; after i_resp, 1 IDLE cycle; then mem_write=1 with mem_addr=0x8000_0100 and mem_wdata=0xA5..A5; d_resp pulses on mem_resp.
- Both caches requesting continuously for 6 transactions -> grants alternate I, D, I, D, I, D with exactly one IDLE cycle between transactions.
- d_read in flight; i_read asserted mid-transaction -> mem_addr stays d_addr, i_resp stays 0 until the dcache finishes; icache is granted on the next IDLE cycle.
- reset pulled low while in SERVE_D with mem_write=1 -> mem_write drops to 0 asynchronously, before the next edge; after release, state is IDLE and the icache wins the first tie.

Source files
------------

// File: rtl/cache_arbiter_pkg.sv
// Shared types for the cache-to-memory arbiter: FSM state encoding, grant
// identity, and the round-robin pick used when both caches want the line port.
package arbiter_types;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    // Meaningful only when at least one requester is pending; a tie goes to
    // whichever side did not win last time.
    function automatic grant_t rr_pick(input logic   i_pend,
                                       input logic   d_pend,
                                       input grant_t last);
        if (i_pend && d_pend) begin
            return (last == GRANT_I) ? GRANT_D : GRANT_I;
        end
        return d_pend ? GRANT_D : GRANT_I;
    endfunction

endpackage

// File: rtl/cache_arbiter.sv
// Shares the single memory line port between icache and dcache. One transaction
// at a time, round-robin on ties, one IDLE turnaround cycle between owners.
module cache_arbiter
    import arbiter_types::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,

    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,

    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp
);

    arb_state_t state_q, state_d;
    grant_t     last_grant_q, last_grant_d;

    logic i_pend;
    logic d_pend;

    assign i_pend = i_read;
    assign d_pend = d_read | d_write;

    // last_grant resets to D so the icache wins the very first tie.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_D;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            IDLE: begin
                if (i_pend || d_pend) begin
                    last_grant_d = rr_pick(i_pend, d_pend, last_grant_q);
                    state_d      = (last_grant_d == GRANT_I) ? SERVE_I : SERVE_D;
                end
            end
            // Completion always drops back to IDLE; that cycle is the turnaround.
            SERVE_I, SERVE_D: begin
                if (mem_resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the registered state only, so an asynchronous
    // reset clears the memory strobes immediately, without waiting for an edge.
    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        i_resp    = 1'b0;
        d_resp    = 1'b0;
        i_rdata   = '0;
        d_rdata   = '0;
        unique case (state_q)
            SERVE_I: begin
                mem_read = i_read;
                mem_addr = i_addr;
                i_resp   = mem_resp;
                i_rdata  = mem_rdata;
            end
            SERVE_D: begin
                mem_read  = d_read;
                mem_write = d_write;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                d_resp    = mem_resp;
                d_rdata   = mem_rdata;
            end
            default: ;
        endcase
    end

endmodule
